// File: rtl/gpio_key_in_pkg.sv
// Shared register map and constants for the key-input GPIO peripheral.
package gpio_key_in_pkg;

  localparam logic [3:0]  KEY_CTRL  = 4'h0;
  localparam logic [3:0]  KEY_DATA  = 4'h4;
  localparam logic [3:0]  KEY_PEND  = 4'h8;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam int EDGE_SEL_LSB = 16;
  localparam int EDGE_SEL_MAX = 16;

  // Only 16 edge-select bits fit above the mask; wider configurations default to press edge.
  function automatic int edge_sel_width(input int num_pins);
    return (num_pins > EDGE_SEL_MAX) ? EDGE_SEL_MAX : num_pins;
  endfunction

endpackage

// File: rtl/gpio_key_debounce.sv
// One key pin: inversion to active-high, 2-flop synchroniser and hold-time debouncer.
module gpio_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = ~pin_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any sample matching the stable level drops the count back to zero.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/gpio_key_in.sv
// Key-input GPIO: debounced levels, edge pending flags and level irq on the peripheral bus.
// Macro GPIO_KEY_IRQ_EN enables PEND, edge select and irq_o; otherwise only mask and DATA.
module gpio_key_in
  import gpio_key_in_pkg::*;
#(
  parameter int NUM_PINS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [31:0]         wr_addr_i,
  input  logic [31:0]         wr_data_i,
  input  logic [31:0]         rd_addr_i,
  output logic [31:0]         rd_data_o,
  input  logic [NUM_PINS-1:0] key_pins_i,
  output logic                irq_o
);

  logic [NUM_PINS-1:0] stable;
  logic [3:0]          wr_off;
  logic [3:0]          rd_off;
  logic                wr_ctrl;
  logic [NUM_PINS-1:0] mask_q, mask_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [31:0]         ctrl_rd, data_rd, pend_rd;
  logic                unused_bus_bits;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (key_pins_i[i]),
      .level_o(stable[i])
    );
  end

  // Base-address selection belongs to the fabric; only the offset nibble is decoded.
  assign wr_off          = wr_addr_i[3:0];
  assign rd_off          = rd_addr_i[3:0];
  assign wr_ctrl         = wr_en_i && (wr_off == KEY_CTRL);
  assign unused_bus_bits = ^{wr_addr_i[31:4], rd_addr_i[31:4], wr_data_i};

`ifdef GPIO_KEY_IRQ_EN
  localparam int SEL_W = edge_sel_width(NUM_PINS);

  logic [SEL_W-1:0]    edge_sel_q, edge_sel_d;
  logic [NUM_PINS-1:0] stable_dly_q, stable_dly_d;
  logic [NUM_PINS-1:0] pend_q, pend_d;
  logic                irq_q, irq_d;
  logic                wr_pend;
  logic [NUM_PINS-1:0] sel_full, rise, fall, evt, w1c;

  assign wr_pend  = wr_en_i && (wr_off == KEY_PEND);
  assign sel_full = NUM_PINS'(edge_sel_q);
  assign rise     = stable & ~stable_dly_q;
  assign fall     = ~stable & stable_dly_q;
  assign evt      = (sel_full & fall) | (~sel_full & rise);
  assign w1c      = wr_pend ? wr_data_i[NUM_PINS-1:0] : '0;
`endif

  always_comb begin
    mask_d = mask_q;
    if (wr_ctrl) mask_d = wr_data_i[NUM_PINS-1:0];
`ifdef GPIO_KEY_IRQ_EN
    edge_sel_d = edge_sel_q;
    if (wr_ctrl) edge_sel_d = wr_data_i[EDGE_SEL_LSB +: SEL_W];
    stable_dly_d = stable;
    // Setting is OR'd in after the clear so a same-cycle edge survives a W1C.
    pend_d = (pend_q & ~w1c) | evt;
    irq_d  = |(pend_q & mask_q);
`endif

    // Read path uses next-state values so a same-cycle write is visible immediately.
    ctrl_rd                  = ZERO_WORD;
    ctrl_rd[NUM_PINS-1:0]    = mask_d;
    data_rd                  = ZERO_WORD;
    data_rd[NUM_PINS-1:0]    = stable;
    pend_rd                  = ZERO_WORD;
`ifdef GPIO_KEY_IRQ_EN
    ctrl_rd[EDGE_SEL_LSB +: SEL_W] = edge_sel_d;
    pend_rd[NUM_PINS-1:0]          = pend_d;
`endif

    case (rd_off)
      KEY_CTRL: rd_data_d = ctrl_rd;
      KEY_DATA: rd_data_d = data_rd;
      KEY_PEND: rd_data_d = pend_rd;
      default:  rd_data_d = ZERO_WORD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      rd_data_q <= ZERO_WORD;
    end else begin
      mask_q    <= mask_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef GPIO_KEY_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_sel_q   <= '0;
      stable_dly_q <= '0;
      pend_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      edge_sel_q   <= edge_sel_d;
      stable_dly_q <= stable_dly_d;
      pend_q       <= pend_d;
      irq_q        <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_gpio_key_in.sv
// Randomised and directed bench for gpio_key_in against a window-based behavioural model.
module tb_gpio_key_in;

  localparam int NP = 4;
  localparam int DB = 4;
`ifdef GPIO_KEY_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [31:0]   wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_addr = '0;
  logic [31:0]   rd_data;
  logic [NP-1:0] pins = '1;
  logic          irq;

  gpio_key_in #(
    .NUM_PINS(NP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .key_pins_i(pins),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: pressed-sample history (newest first), accepted levels and registers.
  logic [NP-1:0] m_hist[$];
  logic [NP-1:0] m_st, m_st_d, m_mask, m_sel, m_pend;
  logic          m_irq;
  logic [31:0]   m_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < DB + 2; i++) m_hist.push_back('0);
    m_st = '0; m_st_d = '0; m_mask = '0; m_sel = '0; m_pend = '0;
    m_irq = 1'b0; m_rd = '0;
  endtask

  task automatic model_step();
    logic [NP-1:0] press_evt, rel_evt, ev, w1c, nst;
    logic          wr_c, wr_p, flip;
    wr_c = wr_en && (wr_addr[3:0] == 4'h0);
    wr_p = wr_en && (wr_addr[3:0] == 4'h8);
    press_evt = m_st & ~m_st_d;
    rel_evt   = ~m_st & m_st_d;
    for (int p = 0; p < NP; p++) ev[p] = m_sel[p] ? rel_evt[p] : press_evt[p];
    m_irq = IRQ_ON && ((m_pend & m_mask) != '0);
    w1c = wr_p ? wr_data[NP-1:0] : '0;
    if (IRQ_ON) m_pend = (m_pend & ~w1c) | ev;
    if (wr_c) begin
      m_mask = wr_data[NP-1:0];
      m_sel  = IRQ_ON ? wr_data[16 +: NP] : '0;
    end
    case (rd_addr[3:0])
      4'h0:    m_rd = {12'b0, m_sel, 12'b0, m_mask};
      4'h4:    m_rd = {28'b0, m_st};
      4'h8:    m_rd = {28'b0, m_pend};
      default: m_rd = '0;
    endcase
    // A level is accepted once the synchronised input has disagreed for DB consecutive cycles.
    for (int p = 0; p < NP; p++) begin
      flip = 1'b1;
      for (int j = 1; j <= DB; j++) if (m_hist[j][p] == m_st[p]) flip = 1'b0;
      nst[p] = flip ? ~m_st[p] : m_st[p];
    end
    m_st_d = m_st;
    m_st   = nst;
    m_hist.push_front(~pins);
    void'(m_hist.pop_back());
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_eq("rd_data", rd_data, m_rd);
    check_eq("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    rd_addr = a;
    cycle();
    d = rd_data;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    wr_en = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 4))
      0:       a[3:0] = 4'h0;
      1:       a[3:0] = 4'h4;
      2:       a[3:0] = 4'h8;
      3:       a[3:0] = 4'hC;
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] v;
    int          n;
    bit          hit;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_eq("init_rd_data", rd_data, 32'h0);
    check_eq("init_irq", {31'b0, irq}, 32'h0);
    run(2);
    rst_n = 1'b1;
    run(2);

    // Reset in the middle of a debounce count
    pins[0] = 1'b0;
    run(3);
    do_reset();
    pins[0] = 1'b1;
    run(2);
    bus_rd(32'h4, v); check_eq("s1_data", v, 32'h0);
    run(10);
    bus_rd(32'h4, v); check_eq("s1_data_late", v, 32'h0);

    // Held press: latency and pending flag
    pins[0] = 1'b0;
    rd_addr = 32'h4;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (rd_data[0]) begin n = i; break; end
    end
    check_eq("s2_press_latency", 32'(n), 32'd7);
    bus_rd(32'h8, v); check_eq("s2_pend", v, IRQ_ON ? 32'h1 : 32'h0);
    pins[0] = 1'b1;
    run(10);
    bus_wr(32'h8, 32'hF);

    // Short glitch is rejected
    pins[1] = 1'b0;
    run(3);
    pins[1] = 1'b1;
    run(10);
    bus_rd(32'h4, v); check_eq("s3_data", v, 32'h0);
    bus_rd(32'h8, v); check_eq("s3_pend", v, 32'h0);

    // Masked press raises irq, W1C drops it
    bus_wr(32'h0, 32'h0000_0004);
    pins[2] = 1'b0;
    run(12);
    bus_rd(32'h8, v); check_eq("s4_pend", v, IRQ_ON ? 32'h4 : 32'h0);
    check_eq("s4_irq", {31'b0, irq}, {31'b0, IRQ_ON});
    bus_wr(32'h8, 32'h4);
    bus_rd(32'h8, v); check_eq("s4_pend_clr", v, 32'h0);
    check_eq("s4_irq_clr", {31'b0, irq}, 32'h0);
    pins[2] = 1'b1;
    run(10);

    // Release-edge select, W1C colliding with the set cycle
    bus_wr(32'h0, 32'h0008_0008);
    pins[3] = 1'b0;
    run(12);
    bus_rd(32'h8, v); check_eq("s5_pend_press", v, 32'h0);
    pins[3] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!m_st[3] && m_st_d[3]) begin
        bus_wr(32'h8, 32'h8);
        hit = 1'b1;
        break;
      end
      cycle();
    end
    check_eq("s5_set_cycle_found", {31'b0, hit}, 32'h1);
    bus_rd(32'h8, v); check_eq("s5_pend_rel", v, IRQ_ON ? 32'h8 : 32'h0);
    check_eq("s5_irq", {31'b0, irq}, {31'b0, IRQ_ON});
    bus_wr(32'h8, 32'h8);

    // Register map boundaries
    bus_wr(32'h0, 32'hFFFF_FFFF);
    bus_rd(32'h0, v); check_eq("ctrl_rb", v, IRQ_ON ? 32'h000F_000F : 32'h0000_000F);
    bus_wr(32'h4, 32'hFFFF_FFFF);
    bus_wr(32'hC, 32'hFFFF_FFFF);
    bus_rd(32'hC, v); check_eq("rd_0xC", v, 32'h0);
    bus_rd(32'h5A5A_0004, v); check_eq("data_alias", v, 32'h0);
    bus_wr(32'h0, 32'h1);
    pins[0] = 1'b0;
    run(12);
    bus_rd(32'hFFFF_FFF4, v); check_eq("s6_data", v, 32'h1);
    bus_rd(32'h8, v); check_eq("s6_pend", v, IRQ_ON ? 32'h1 : 32'h0);
    check_eq("s6_irq", {31'b0, irq}, {31'b0, IRQ_ON});
    pins[0] = 1'b1;
    run(10);
    bus_wr(32'h8, 32'hF);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < NP; p++) if ($urandom_range(0, 5) == 0) pins[p] = ~pins[p];
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = rand_addr();
      wr_data = $urandom;
      rd_addr = rand_addr();
      if (i == 1500) do_reset();
      else cycle();
    end
    wr_en = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
